// File: rtl/vram_arbiter_if.sv
// Pixel-fetch, CPU and VRAM signals of the VRAM arbiter grouped as one bundle.
// slave = arbiter side; master = timing block / CPU / VRAM side.
interface vram_arbiter_if;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic [11:0] vga_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [11:0] cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  modport slave (
    input  h_addr, v_addr, valid, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, cpu_ready, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output h_addr, v_addr, valid, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, cpu_ready, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out always wins, CPU reads/writes use blanking.
// Define VRAM_ARB_WBUF_EN to add a WBUF_DEPTH-entry posted-write FIFO.
module vram_arbiter #(
  parameter int H_RES      = 640,
  parameter int WBUF_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  if ((WBUF_DEPTH < 2) || ((WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("WBUF_DEPTH must be a power of two >= 2");
  end

  logic [18:0] pix_addr;
  logic        disp_q;
  logic        rvalid_q;
  logic [11:0] rdata_q;
  logic        cpu_ready;
  logic        rd_acc;
  logic        wr_acc;
  logic        cpu_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;

  assign pix_addr = 19'(bus.v_addr) * 19'(H_RES) + 19'(bus.h_addr);
  assign rd_acc   = bus.cpu_req && !bus.cpu_we && cpu_ready;
  assign wr_acc   = bus.cpu_req &&  bus.cpu_we && cpu_ready;

`ifdef VRAM_ARB_WBUF_EN
  localparam int PTR_W = $clog2(WBUF_DEPTH);

  logic [18:0]      waddr_q [WBUF_DEPTH];
  logic [11:0]      wdat_q  [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             empty, full, drain;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W + 1)'(WBUF_DEPTH));
  assign drain = !rst && !bus.valid && !empty;

  // Writes only need FIFO space; reads must wait until every earlier write has committed.
  always_comb begin
    cpu_ready = 1'b0;
    if (!rst) begin
      if (bus.cpu_we) cpu_ready = !full;
      else            cpu_ready = !bus.valid && empty;
    end
  end

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = drain  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc && !drain)      cnt_d = cnt_q + 1'b1;
    else if (!wr_acc && drain) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      waddr_q[wr_ptr_q] <= bus.cpu_addr;
      wdat_q[wr_ptr_q]  <= bus.cpu_wdata;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (rst) begin
      mem_en = 1'b0;
    end else if (bus.valid) begin
      mem_en   = 1'b1;
      mem_addr = pix_addr;
    end else if (drain) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = waddr_q[rd_ptr_q];
      mem_wdata = wdat_q[rd_ptr_q];
    end else if (rd_acc) begin
      mem_en = 1'b1;
    end
  end
`else
  assign cpu_ready = !rst && !bus.valid;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (rst) begin
      mem_en = 1'b0;
    end else if (bus.valid) begin
      mem_en   = 1'b1;
      mem_addr = pix_addr;
    end else if (rd_acc || wr_acc) begin
      mem_en = 1'b1;
      mem_we = wr_acc;
    end
  end
`endif

  // Return strobe is masked during reset so an in-flight read never surfaces.
  assign cpu_rvalid = rvalid_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      disp_q   <= bus.valid;
      rvalid_q <= rd_acc;
      if (cpu_rvalid) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.vga_data   = disp_q ? bus.mem_rdata : 12'h000;
  assign bus.cpu_ready  = cpu_ready;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : rdata_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus queues expected VRAM
// accesses and read returns; a negedge monitor pops and compares them.
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter #(.H_RES(640), .WBUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_scan[$];
  int  exp_cpurd[$];
  int  exp_rdata[$];
  wr_t exp_wr[$];
  logic [11:0] vram [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event, value %0h (t=%0t)", name, act, $time);
  endtask

  // VRAM model: synchronous single-port memory, read data one cycle later
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= 12'h000;
    end else if (bus.mem_en) begin
      if (bus.mem_we) vram[int'(bus.mem_addr)] = bus.mem_wdata;
      else bus.mem_rdata <= vram.exists(int'(bus.mem_addr)) ? vram[int'(bus.mem_addr)] : 12'h000;
    end
  end

  // Monitor: every VRAM access and every read return must match a queued expectation
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_cpu_ready", bus.cpu_ready, 0);
    end else if (bus.mem_en) begin
      if (bus.valid) begin
        if (exp_scan.size() == 0) unexpected("scan_access", bus.mem_addr);
        else begin
          chk("scan_addr", bus.mem_addr, exp_scan.pop_front());
          chk("scan_we", bus.mem_we, 0);
        end
      end else if (bus.mem_we) begin
        if (exp_wr.size() == 0) unexpected("vram_write", bus.mem_addr);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", bus.mem_addr, w.addr);
          chk("wr_data", bus.mem_wdata, w.data);
        end
      end else begin
        if (exp_cpurd.size() == 0) unexpected("cpu_read_access", bus.mem_addr);
        else chk("rd_addr", bus.mem_addr, exp_cpurd.pop_front());
      end
    end else if (bus.valid) begin
      unexpected("scan_missing", bus.mem_en);
    end
    if (bus.cpu_rvalid) begin
      if (exp_rdata.size() == 0) unexpected("cpu_rvalid", bus.cpu_rdata);
      else chk("rdata", bus.cpu_rdata, exp_rdata.pop_front());
    end
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic set_scan(input int h, input int v, input int a);
    bus.valid  = 1'b1;
    bus.h_addr = 10'(h);
    bus.v_addr = 10'(v);
    exp_scan.push_back(a);
  endtask

  task automatic blank();
    bus.valid  = 1'b0;
    bus.h_addr = '0;
    bus.v_addr = '0;
  endtask

  task automatic cpu(input logic req, input logic we, input int addr, input int data);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = 19'(addr);
    bus.cpu_wdata = 12'(data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    blank();
    cpu(1'b0, 1'b0, 0, 0);
    vram[1285]   = 12'h5A5;
    vram[307199] = 12'hFFF;
    vram[16]     = 12'h123;
    vram[0]      = 12'h0E1;

    // Reset, including a cycle with valid high (must not reach VRAM)
    to_pos();
    bus.valid = 1'b1;
    to_pos();
    rst = 1'b0;
    blank();
    to_neg();
    chk("reset_vga_data", bus.vga_data, 0);
    chk("reset_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("reset_cpu_rdata", bus.cpu_rdata, 0);
    chk("reset_mem_en", bus.mem_en, 0);

    // Scan-out addressing and one-cycle pixel latency
    to_pos();
    set_scan(5, 2, 1285);
    to_pos();
    set_scan(639, 479, 307199);
    to_neg();
    chk("vga_first_pixel", bus.vga_data, 12'h5A5);
    to_pos();
    blank();
    to_neg();
    chk("vga_last_pixel", bus.vga_data, 12'hFFF);
    to_pos();
    to_neg();
    chk("vga_blank", bus.vga_data, 0);

    // CPU read held through active video, granted on first blanking cycle
    to_pos();
    cpu(1'b1, 1'b0, 16, 0);
    exp_cpurd.push_back(16);
    exp_rdata.push_back(12'h123);
    for (int i = 0; i < 3; i++) begin
      set_scan(0, 0, 0);
      to_neg();
      chk("rd_stall_ready", bus.cpu_ready, 0);
      to_pos();
    end
    blank();
    to_neg();
    chk("rd_grant_ready", bus.cpu_ready, 1);
    to_pos();
    cpu(1'b0, 1'b0, 0, 0);
    to_neg();
    chk("rvalid_pulse", bus.cpu_rvalid, 1);
    to_pos();
    to_neg();
    chk("rvalid_single", bus.cpu_rvalid, 0);
    chk("rdata_hold", bus.cpu_rdata, 12'h123);
    to_pos();

`ifndef VRAM_ARB_WBUF_EN
    // Direct write waits for blanking, then hits VRAM in the acceptance cycle
    cpu(1'b1, 1'b1, 'h200, 'h3C3);
    exp_wr.push_back('{addr: 'h200, data: 'h3C3});
    for (int i = 0; i < 2; i++) begin
      set_scan(0, 0, 0);
      to_neg();
      chk("dwr_stall_ready", bus.cpu_ready, 0);
      to_pos();
    end
    blank();
    to_neg();
    chk("dwr_ready", bus.cpu_ready, 1);
    chk("dwr_mem_en", bus.mem_en, 1);
    chk("dwr_mem_we", bus.mem_we, 1);
    to_pos();
    cpu(1'b1, 1'b0, 'h200, 0);
    exp_cpurd.push_back('h200);
    exp_rdata.push_back(12'h3C3);
    to_neg();
    chk("dwr_readback_ready", bus.cpu_ready, 1);
    to_pos();
    cpu(1'b0, 1'b0, 0, 0);
    to_pos();
`else
    // Five writes during active video: four fill the buffer, fifth stalls
    for (int i = 0; i < 5; i++) begin
      set_scan(0, 0, 0);
      cpu(1'b1, 1'b1, 'h300 + i, 'h700 + i);
      to_neg();
      if (i < 4) begin
        chk("wbuf_accept", bus.cpu_ready, 1);
        exp_wr.push_back('{addr: 'h300 + i, data: 'h700 + i});
      end else begin
        chk("wbuf_full", bus.cpu_ready, 0);
      end
      to_pos();
    end
    set_scan(0, 0, 0);
    to_neg();
    chk("wbuf_full_hold", bus.cpu_ready, 0);
    to_pos();
    blank();
    to_neg();
    chk("drain0_ready", bus.cpu_ready, 0);
    chk("drain0_we", bus.mem_en && bus.mem_we, 1);
    to_pos();
    to_neg();
    chk("fifth_accept", bus.cpu_ready, 1);
    chk("drain1_we", bus.mem_en && bus.mem_we, 1);
    exp_wr.push_back('{addr: 'h304, data: 'h704});
    to_pos();
    cpu(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("drain_rest_we", bus.mem_en && bus.mem_we, 1);
      to_pos();
    end
    to_neg();
    chk("drain_done", bus.mem_en, 0);
    to_pos();

    // Read-after-write: read waits for the buffered write to commit
    cpu(1'b1, 1'b1, 'h100, 'hABC);
    to_neg();
    chk("raw_wr_ready", bus.cpu_ready, 1);
    exp_wr.push_back('{addr: 'h100, data: 'hABC});
    to_pos();
    cpu(1'b1, 1'b0, 'h100, 0);
    exp_cpurd.push_back('h100);
    exp_rdata.push_back(12'hABC);
    to_neg();
    chk("raw_rd_hold", bus.cpu_ready, 0);
    to_pos();
    to_neg();
    chk("raw_rd_grant", bus.cpu_ready, 1);
    to_pos();
    cpu(1'b0, 1'b0, 0, 0);
    to_pos();

    // Reset with three buffered writes: they must never reach VRAM
    for (int i = 0; i < 3; i++) begin
      set_scan(0, 0, 0);
      cpu(1'b1, 1'b1, 'h400 + i, 'h800 + i);
      to_neg();
      chk("pre_rst_accept", bus.cpu_ready, 1);
      to_pos();
    end
    cpu(1'b0, 1'b0, 0, 0);
    blank();
    rst = 1'b1;
    to_pos();
    bus.valid = 1'b1;
    to_pos();
    rst = 1'b0;
    blank();
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("post_rst_idle", bus.mem_en, 0);
      to_pos();
    end
`endif

    // Reset lands on the return cycle of an accepted read: no strobe, data cleared
    cpu(1'b1, 1'b0, 1285, 0);
    exp_cpurd.push_back(1285);
    to_neg();
    chk("inflight_rd_ready", bus.cpu_ready, 1);
    to_pos();
    cpu(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    to_neg();
    chk("rvalid_in_reset", bus.cpu_rvalid, 0);
    to_pos();
    rst = 1'b0;
    to_neg();
    chk("rvalid_after_reset", bus.cpu_rvalid, 0);
    chk("rdata_after_reset", bus.cpu_rdata, 0);
    to_pos();
    to_pos();

    chk("scan_queue_empty", exp_scan.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_cpurd.size(), 0);
    chk("rdata_queue_empty", exp_rdata.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
